uart_tx_fifo: RTL

- Byte FIFO plus dispatch FSM between the core's UART transmit register write and the UART_TX serializer.
- The core writes bytes without polling tx_active; the block buffers them and launches each on UART_TX with a one-cycle start_TX pulse.
- It waits for each frame to complete before launching the next.
- Reports fill level, overflow and handshake-timeout status for the core to read back.

---
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART serializer: buffers core writes and launches one frame at a time
// with a single-cycle start_TX pulse, reporting fill level, overflow and launch-timeout status.
module uart_tx_fifo #(
   parameter int DEPTH_BITS  = 4,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  sync_reset,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   input  logic                  flush,
   input  logic                  clr_status,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_BITS:0]   count,
   output logic                  overflow,
   output logic                  timeout_err,
   output logic                  busy,
   output logic                  start_TX,
   output logic [7:0]            tx_data,
   input  logic                  tx_active,
   output logic [1:0]            o_dbg_state
);

   localparam int                  DEPTH     = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS + 1)'(DEPTH);
   localparam logic [7:0]          TMO_LAST  = 8'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_START   = 2'd1,
      S_WAIT_HI = 2'd2,
      S_WAIT_LO = 2'd3
   } state_t;

   state_t                r_state;
   logic [7:0]            r_mem [DEPTH];
   logic [DEPTH_BITS-1:0] r_wr_ptr;
   logic [DEPTH_BITS-1:0] r_rd_ptr;
   logic [DEPTH_BITS:0]   r_count;
   logic [7:0]            r_tmo_cnt;
   logic                  r_overflow;
   logic                  r_timeout_err;
   logic                  r_start_tx;
   logic [7:0]            r_tx_data;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_ovf_set;
   logic                  w_tmo_hit;

   // Handshake: start_TX is high for exactly the S_START cycle and is only raised from S_IDLE
   // with tx_active low; the serializer acknowledges by raising tx_active and ends the frame
   // by dropping it. A launch that never sees tx_active rise is abandoned after ACK_TIMEOUT cycles.
   assign w_full    = (r_count == DEPTH_CNT);
   assign w_empty   = (r_count == '0);
   assign w_push    = wr_en && !w_full && !flush;
   assign w_ovf_set = wr_en && w_full && !flush;
   assign w_pop     = (r_state == S_IDLE) && !w_empty && !tx_active && !flush;
   assign w_tmo_hit = (r_state == S_WAIT_HI) && !tx_active && (r_tmo_cnt == TMO_LAST);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (sync_reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         r_state    <= S_IDLE;
         r_start_tx <= 1'b0;
         r_tx_data  <= 8'h00;
         r_tmo_cnt  <= 8'h00;
      end else begin
         r_start_tx <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_tx_data  <= r_mem[r_rd_ptr];
                  r_start_tx <= 1'b1;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               r_tmo_cnt <= 8'h00;
               r_state   <= S_WAIT_HI;
            end
            S_WAIT_HI: begin
               if (tx_active) begin
                  r_state <= S_WAIT_LO;
               end else if (r_tmo_cnt == TMO_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
            end
            S_WAIT_LO: begin
               if (!tx_active) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Set events take precedence over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         r_overflow    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_overflow    <= w_ovf_set || (r_overflow && !clr_status);
         r_timeout_err <= w_tmo_hit || (r_timeout_err && !clr_status);
      end
   end

   assign full        = w_full;
   assign empty       = w_empty;
   assign count       = r_count;
   assign overflow    = r_overflow;
   assign timeout_err = r_timeout_err;
   assign busy        = (r_state != S_IDLE) || !w_empty;
   assign start_TX    = r_start_tx;
   assign tx_data     = r_tx_data;
   assign o_dbg_state = r_state;

endmodule
